// File: rtl/kp_pkg.sv
// Shared keycodes, controller state type and BCD conversion helpers for the keypad entry block.
package kp_pkg;

  localparam logic [3:0] KEY_STOP  = 4'hA;
  localparam logic [3:0] KEY_START = 4'hB;
  localparam logic [3:0] KEY_NEXT  = 4'hC;
  localparam logic [3:0] KEY_BKSP  = 4'hD;

  // Widest field the helpers accept; callers zero-extend narrower fields.
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned BCD_W      = MAX_DIGITS * 4;

  typedef enum logic [1:0] {EDIT, ARM, RUN} kp_state_e;

  // Upper (ndig-2) digits are minutes, low two digits are seconds; seconds are not clamped.
  function automatic logic [31:0] bcd_time2bin(input logic [BCD_W-1:0] bcd, input int ndig);
    logic [31:0] mins;
    mins = '0;
    for (int i = MAX_DIGITS - 1; i >= 2; i--) begin
      if (i < ndig) mins = mins * 32'd10 + 32'(bcd[i*4 +: 4]);
    end
    return mins * 32'd60 + 32'(bcd[7:4]) * 32'd10 + 32'(bcd[3:0]);
  endfunction

  // Only the low three digits count; result saturates at 100 %.
  function automatic logic [7:0] bcd_dc2bin(input logic [BCD_W-1:0] bcd);
    logic [11:0] v;
    v = 12'(bcd[11:8]) * 12'd100 + 12'(bcd[7:4]) * 12'd10 + 12'(bcd[3:0]);
    return (v > 12'd100) ? 8'd100 : v[7:0];
  endfunction

endpackage

// File: rtl/kp_entry_ctrl_if.sv
// Keypad-side inputs and heater/display-side outputs of the entry controller.
interface kp_entry_ctrl_if #(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned NFIELDS = 2,
  parameter int unsigned TW      = 10
) ();
  localparam int unsigned FW = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;

  logic                        kphit;
  logic [3:0]                  num;
  logic [DIGITS*4-1:0]         tload;
  logic                        write_ack;
  logic                        start;
  logic                        stop;
  logic                        write;
  logic [FW-1:0]               field_sel;
  logic [NFIELDS*DIGITS*4-1:0] disp;
  logic [TW-1:0]               time_bin;
  logic [7:0]                  dc_bin;

  // Environment side: keypad scanner, countdown timer and heater controller.
  modport master (
    output kphit, num, tload, write_ack,
    input  start, stop, write, field_sel, disp, time_bin, dc_bin
  );

  // Controller side.
  modport slave (
    input  kphit, num, tload, write_ack,
    output start, stop, write, field_sel, disp, time_bin, dc_bin
  );
endinterface

// File: rtl/kp_key_filter.sv
// Single-accept key filter: one key_valid pulse per press, then a lockout and a required release.
module kp_key_filter #(
  parameter int unsigned DEBOUNCE = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       kphit,
  input  logic [3:0] num,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int unsigned LW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          armed_q, armed_d;
  logic [LW-1:0] lockout_q, lockout_d;
  logic          idle;

  assign idle      = (lockout_q == '0);
  assign key_valid = kphit & armed_q & idle;
  assign key_code  = num;

  // Accept disarms and loads the lockout; re-arm only once released and the lockout has drained.
  always_comb begin
    armed_d   = armed_q;
    lockout_d = lockout_q;
    if (key_valid) begin
      armed_d   = 1'b0;
      lockout_d = LW'(DEBOUNCE - 1);
    end else begin
      if (!idle) lockout_d = lockout_q - LW'(1);
      if (!kphit && idle) armed_d = 1'b1;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q   <= 1'b1;
      lockout_q <= '0;
    end else begin
      armed_q   <= armed_d;
      lockout_q <= lockout_d;
    end
  end

endmodule

// File: rtl/kp_entry_ctrl.sv
// Keypad entry controller: BCD field editing plus the stop/arm/run handshake to the heater.
module kp_entry_ctrl
  import kp_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned NFIELDS  = 2,
  parameter int unsigned DEBOUNCE = 1024,
  parameter int unsigned TW       = 10
) (
  input logic             clk,
  input logic             reset_n,
  kp_entry_ctrl_if.slave  bus
);
  localparam int unsigned FWID = DIGITS * 4;
  localparam int unsigned FW   = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;

  kp_state_e                      state_q, state_d;
  logic [NFIELDS-1:0][FWID-1:0]   fields_q, fields_d;
  logic [FW-1:0]                  sel_q, sel_d;
  logic                           key_valid;
  logic [3:0]                     key_code;
  logic [BCD_W-1:0]               time_bcd, dc_bcd;
  logic [TW-1:0]                  time_bin;

  kp_key_filter #(
    .DEBOUNCE (DEBOUNCE)
  ) u_key_filter (
    .clk       (clk),
    .reset_n   (reset_n),
    .kphit     (bus.kphit),
    .num       (bus.num),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign time_bcd = BCD_W'(fields_q[0]);
  if (NFIELDS > 1) begin : g_dc
    assign dc_bcd = BCD_W'(fields_q[1]);
  end else begin : g_no_dc
    assign dc_bcd = '0;
  end

  assign time_bin      = TW'(bcd_time2bin(time_bcd, int'(DIGITS)));
  assign bus.time_bin  = time_bin;
  assign bus.dc_bin    = bcd_dc2bin(dc_bcd);
  assign bus.disp      = fields_q;
  assign bus.field_sel = sel_q;
  assign bus.start     = (state_q == RUN);
  assign bus.stop      = (state_q == EDIT);
  assign bus.write     = (state_q == ARM);

  // Key decode and handshake; an accepted stop key overrides everything, including write_ack.
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    sel_d    = sel_q;
    if (key_valid && key_code == KEY_STOP) begin
      state_d     = EDIT;
      fields_d[0] = bus.tload;
      // Clear is applied after the reload, so it wins when field 0 is the one selected.
      if (state_q == EDIT) fields_d[sel_q] = '0;
    end else begin
      unique case (state_q)
        EDIT: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              fields_d[sel_q] = {fields_q[sel_q][FWID-5:0], key_code};
            end else if (key_code == KEY_BKSP) begin
              fields_d[sel_q] = {4'h0, fields_q[sel_q][FWID-1:4]};
            end else if (key_code == KEY_NEXT) begin
              sel_d = (sel_q == FW'(NFIELDS - 1)) ? '0 : sel_q + FW'(1);
            end else if (key_code == KEY_START && time_bin != '0) begin
              state_d = ARM;
            end
          end
        end
        ARM:     if (bus.write_ack) state_d = RUN;
        RUN:     ;
        default: state_d = EDIT;
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EDIT;
      fields_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: tb/tb_kp_entry_ctrl.sv
// Directed bench for kp_entry_ctrl with a short debounce.
module tb_kp_entry_ctrl;
  localparam int unsigned DIGITS   = 3;
  localparam int unsigned NFIELDS  = 2;
  localparam int unsigned DEBOUNCE = 4;
  localparam int unsigned TW       = 10;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  kp_entry_ctrl_if #(.DIGITS(DIGITS), .NFIELDS(NFIELDS), .TW(TW)) bus ();

  kp_entry_ctrl #(
    .DIGITS   (DIGITS),
    .NFIELDS  (NFIELDS),
    .DEBOUNCE (DEBOUNCE),
    .TW       (TW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a key and stop at the negedge right after it was accepted, key still held.
  task automatic press_hold(input logic [3:0] k);
    @(negedge clk);
    bus.kphit = 1'b1;
    bus.num   = k;
    @(negedge clk);
  endtask

  task automatic release_key();
    bus.kphit = 1'b0;
    repeat (DEBOUNCE + 1) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    press_hold(k);
    release_key();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    bus.kphit     = 1'b0;
    bus.num       = 4'h0;
    bus.tload     = '0;
    bus.write_ack = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_stop", 32'(bus.stop), 32'd1);
    chk("rst_write", 32'(bus.write), 32'd0);
    chk("rst_sel", 32'(bus.field_sel), 32'd0);
    chk("rst_disp", 32'(bus.disp), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Digit entry into field 0.
    press(4'h1); press(4'h3); press(4'h0);
    chk("entry_disp", 32'(bus.disp), 32'h000130);
    chk("entry_time", 32'(bus.time_bin), 32'd90);

    // Held key enters exactly one digit.
    @(negedge clk);
    bus.kphit = 1'b1;
    bus.num   = 4'h5;
    repeat (20) @(negedge clk);
    release_key();
    chk("hold_disp", 32'(bus.disp), 32'h000305);
    chk("hold_time", 32'(bus.time_bin), 32'd185);

    // Field 1 entry, saturation and backspace.
    press(4'hC);
    chk("next_sel", 32'(bus.field_sel), 32'd1);
    press(4'h1); press(4'h5); press(4'h0);
    chk("dc_disp", 32'(bus.disp), 32'h150305);
    chk("dc_sat", 32'(bus.dc_bin), 32'd100);
    press(4'hD);
    chk("bksp_disp", 32'(bus.disp), 32'h015305);
    chk("bksp_dc", 32'(bus.dc_bin), 32'd15);

    // Stop in EDIT: field 0 reloads from tload (0), selected field 1 cleared.
    bus.tload = 12'h000;
    press(4'hA);
    chk("clr_disp", 32'(bus.disp), 32'h0);
    chk("clr_sel", 32'(bus.field_sel), 32'd1);

    // Zero-time start lockout.
    press(4'hB);
    chk("zero_stop", 32'(bus.stop), 32'd1);
    chk("zero_write", 32'(bus.write), 32'd0);

    // Wrap to field 0, enter 1:30 and start.
    press(4'hC);
    chk("wrap_sel", 32'(bus.field_sel), 32'd0);
    press(4'h1); press(4'h3); press(4'h0);
    press_hold(4'hB);
    chk("arm_write", 32'(bus.write), 32'd1);
    chk("arm_stop", 32'(bus.stop), 32'd0);
    chk("arm_start", 32'(bus.start), 32'd0);
    release_key();
    chk("arm_hold", 32'(bus.write), 32'd1);
    bus.write_ack = 1'b1;
    @(negedge clk);
    bus.write_ack = 1'b0;
    chk("ack_write", 32'(bus.write), 32'd0);
    chk("ack_start", 32'(bus.start), 32'd1);
    chk("ack_stop", 32'(bus.stop), 32'd0);

    // RUN ignores digits and next-field.
    press(4'h7);
    press(4'hC);
    chk("run_disp", 32'(bus.disp), 32'h000130);
    chk("run_sel", 32'(bus.field_sel), 32'd0);

    // Stop from RUN reloads field 0 from the timer.
    bus.tload = 12'h045;
    press(4'hA);
    chk("abort_stop", 32'(bus.stop), 32'd1);
    chk("abort_start", 32'(bus.start), 32'd0);
    chk("abort_disp", 32'(bus.disp), 32'h000045);
    chk("abort_time", 32'(bus.time_bin), 32'd45);

    // Stop coinciding with write_ack: stop wins.
    press(4'hB);
    chk("arm2_write", 32'(bus.write), 32'd1);
    bus.tload = 12'h020;
    @(negedge clk);
    bus.kphit     = 1'b1;
    bus.num       = 4'hA;
    bus.write_ack = 1'b1;
    @(negedge clk);
    bus.write_ack = 1'b0;
    chk("race_write", 32'(bus.write), 32'd0);
    chk("race_stop", 32'(bus.stop), 32'd1);
    chk("race_start", 32'(bus.start), 32'd0);
    chk("race_disp", 32'(bus.disp), 32'h000020);
    release_key();

    // write_ack in EDIT is ignored.
    bus.write_ack = 1'b1;
    @(negedge clk);
    bus.write_ack = 1'b0;
    chk("stray_ack_stop", 32'(bus.stop), 32'd1);
    chk("stray_ack_start", 32'(bus.start), 32'd0);

    // Asynchronous reset mid-ARM and mid-lockout.
    press(4'hC); press(4'h4); press(4'hC);
    chk("pre_rst_disp", 32'(bus.disp), 32'h004020);
    press_hold(4'hB);
    chk("pre_rst_write", 32'(bus.write), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_write", 32'(bus.write), 32'd0);
    chk("async_stop", 32'(bus.stop), 32'd1);
    chk("async_start", 32'(bus.start), 32'd0);
    chk("async_disp", 32'(bus.disp), 32'h0);
    chk("async_sel", 32'(bus.field_sel), 32'd0);
    bus.kphit = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    press(4'h9);
    chk("post_rst_disp", 32'(bus.disp), 32'h000009);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kp_entry_ctrl.md
# kp_entry_ctrl

Parametrised keypad entry controller for the toaster. Turns debounced 4x4 keypad codes into up to NFIELDS editable BCD entry fields, and runs the stop/arm/run control sequence with a write/ack handshake toward the heater controller. Sits between the keypad scanner and the heater controller/countdown timer. Adds several behaviours: single-accept per key press, field selection, backspace, zero-time start lockout, duty-cycle saturation and abort during the handshake.

## Interface
- DIGITS, 3, BCD digits per field (minimum 3)
- NFIELDS, 2, entry fields; field 0 = cook time, field 1 = duty cycle %
- DEBOUNCE, 1024, lockout cycles after an accepted key (minimum 1)
- TW, 10, width of time_bin
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- kphit  in  1  a key is currently pressed
- num  in  4  keycode: 0-9 digit, A stop/clear, B start, C next field, D backspace; E/F ignored
- tload  in  DIGITS*4  remaining time (BCD) from the countdown timer
- write_ack  in  1  heater controller has latched time_bin/dc_bin
- start  out  1  cooking active
- stop  out  1  stopped/editing
- write  out  1  parameter write request
- field_sel  out  $clog2(NFIELDS) (min 1)  field currently being edited
- disp  out  NFIELDS*DIGITS*4  all fields; field f occupies bits [f*DIGITS*4 +: DIGITS*4]
- time_bin  out  TW  field 0 in seconds
- dc_bin  out  8  field 1 as a binary percentage, saturated to 100

## Operation
- Reset values:
  - start=0, stop=1, write=0, field_sel=0.
  - All fields 0, state EDIT, lockout=0, armed=1.
- Key acceptance: a key is accepted in the cycle where kphit=1, armed=1 and lockout=0.
  - On acceptance: armed<=0 and lockout<=DEBOUNCE-1.
  - lockout decrements to 0 and saturates there.
  - armed<=1 in any cycle where kphit=0 and lockout=0.
  - Result: one action per physical press.
- States:
  - EDIT: stop=1, start=0.
  - ARM: write=1, start=0, stop=0.
  - RUN: start=1, stop=0.
- EDIT, digit: the selected field shifts left one BCD digit; num enters the low digit and the top digit is discarded.
- EDIT, D: the selected field shifts right; 0 enters the top digit.
- EDIT, C: field_sel <= (field_sel+1) mod NFIELDS.
- EDIT, B: if time_bin≠0, go to ARM with write<=1. If time_bin=0, B is ignored and the state stays EDIT.
- ARM, write_ack=1: write<=0, go to RUN.
- Any state, A: go to EDIT with write<=0 and field 0<=tload; other fields are kept. In EDIT, A also clears field field_sel to 0.
- RUN: digits, B, C and D are ignored.
- write_ack outside ARM is ignored.
- Conversion (combinational from registers):
  - time_bin = (upper DIGITS-2 digits as decimal)*60 + tens*10 + ones. Seconds tens digits of 6-9 are not clamped, e.g. 1:75 → 135.
  - The result is truncated to TW bits.
  - dc_bin = hundreds*100 + tens*10 + ones. Digits above the hundreds digit are ignored. Values >100 → 100.
- Simultaneous events:
  - A accepted in the same cycle as write_ack: A wins, state EDIT, write=0.
  - reset_n low forces reset values immediately, including mid-lockout and mid-handshake.

## Timing
- An accepted key's effect is visible on registered outputs the cycle after acceptance.
- time_bin, dc_bin and disp are valid in the same cycle as the field registers.
- The write rise follows B acceptance by 1 cycle.
- After write_ack is sampled high: write falls and start rises on the next cycle.
- write holds high until write_ack or A; there is no timeout.
- Minimum interval between accepted keys is DEBOUNCE cycles, and a release is required in between.

## Structure
- Package kp_pkg holds:
  - Keycode localparams KEY_STOP=4'hA, KEY_START=4'hB, KEY_NEXT=4'hC, KEY_BKSP=4'hD.
  - State enum {EDIT, ARM, RUN}.
  - Functions bcd_time2bin and bcd_dc2bin.
- Sub-module kp_key_filter holds the armed/lockout logic. Inputs: clk, reset_n, kphit, num. Outputs: key_valid pulse and key_code.

## Test plan
(DEBOUNCE=4 in the bench.)
- After reset, press 1,3,0 in field 0 → disp field0=12'h130, time_bin=90.
- Hold key 5 for 20 cycles → exactly one digit entered.
- Press C, then 1,5,0 → field_sel=1, dc_bin=100. Backspace (D) → field1=12'h015, dc_bin=15.
- All fields zero, press B → state stays EDIT, write stays 0.
- With time 1:30, press B → write=1 the next cycle. Pulse write_ack → write=0, start=1 one cycle later.
- In RUN with tload=12'h045, press A → stop=1, start=0, field0=12'h045. Press A while write=1 with write_ack also asserted in the same cycle → EDIT, write=0.
- Assert reset_n low mid-ARM → immediately start=0, stop=1, write=0, fields 0.
